// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift engine: mode encodings and
// the frame-size helper used to size the deserializer staging register.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_DESER = 3'b110;
  localparam logic [2:0] MODE_ASR   = 3'b111;

  function automatic int chunks_f(input int width, input int shift_w);
    return (width + shift_w - 1) / shift_w;
  endfunction

endpackage

// File: rtl/shift_deser_stage.sv
// Deserializer staging register and chunk counter; flags the cycle in which
// a complete frame is ready and presents the frame for the main register.
module shift_deser_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [2:0]         mode_i,
  input  logic [SHIFT_W-1:0] serial_in_i,
  output logic [WIDTH-1:0]   frame_o,
  output logic               commit_o,
  output logic               pending_o
);

  localparam int CHUNKS  = chunks_f(WIDTH, SHIFT_W);
  localparam int STAGE_W = CHUNKS * SHIFT_W;
  localparam int CNT_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  logic [STAGE_W-1:0] stage_q, stage_d, stage_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               unused_bits;

  assign stage_shift = {serial_in_i, stage_q[STAGE_W-1:SHIFT_W]};
  assign frame_o     = stage_shift[WIDTH-1:0];
  assign pending_o   = (cnt_q != '0);
  // Lowest chunk falls off the shift and padding bits above WIDTH are dropped.
  assign unused_bits = ^{stage_q[SHIFT_W-1:0], stage_shift};

  always_comb begin
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_HOLD: ;
        MODE_DESER: begin
          stage_d = stage_shift;
          if (cnt_q == LAST_CNT) begin
            commit_o = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Any other operation abandons the partial frame; stage goes stale.
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/param_shift_engine.sv
// Universal WIDTH-bit shift register: shifts/rotates SHIFT_W bits per cycle,
// parallel load, and serial-chunk deserialization into the main register.
module param_shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [SHIFT_W-1:0] serial_in,
  input  logic [WIDTH-1:0]   parallel_in,
  output logic [WIDTH-1:0]   parallel_output,
  output logic [SHIFT_W-1:0] serial_out,
  output logic               frame_done,
  output logic               frame_pending
);

  logic [WIDTH-1:0]   d_q, d_d, frame;
  logic [SHIFT_W-1:0] so_q, so_d;
  logic               done_q, done_d;
  logic               commit;

  shift_deser_stage #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) u_deser (
    .clk         (clk),
    .reset       (reset),
    .en_i        (en),
    .mode_i      (mode),
    .serial_in_i (serial_in),
    .frame_o     (frame),
    .commit_o    (commit),
    .pending_o   (frame_pending)
  );

  always_comb begin
    d_d    = d_q;
    so_d   = so_q;
    done_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHR: begin
          d_d  = {serial_in, d_q[WIDTH-1:SHIFT_W]};
          so_d = d_q[SHIFT_W-1:0];
        end
        MODE_SHL: begin
          d_d  = {d_q[WIDTH-1-SHIFT_W:0], serial_in};
          so_d = d_q[WIDTH-1 -: SHIFT_W];
        end
        MODE_ROR: begin
          d_d  = {d_q[SHIFT_W-1:0], d_q[WIDTH-1:SHIFT_W]};
          so_d = d_q[SHIFT_W-1:0];
        end
        MODE_ROL: begin
          d_d  = {d_q[WIDTH-1-SHIFT_W:0], d_q[WIDTH-1 -: SHIFT_W]};
          so_d = d_q[WIDTH-1 -: SHIFT_W];
        end
        MODE_LOAD: d_d = parallel_in;
        MODE_DESER: begin
          if (commit) begin
            d_d    = frame;
            done_d = 1'b1;
          end
        end
        MODE_ASR: begin
          d_d  = {{SHIFT_W{d_q[WIDTH-1]}}, d_q[WIDTH-1:SHIFT_W]};
          so_d = d_q[SHIFT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q    <= '0;
      so_q   <= '0;
      done_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      so_q   <= so_d;
      done_q <= done_d;
    end
  end

  assign parallel_output = d_q;
  assign serial_out      = so_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// Directed bench for param_shift_engine at WIDTH=8, SHIFT_W=3.
module tb_param_shift_engine;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [2:0] serial_in;
  logic [7:0] parallel_in;
  logic [7:0] parallel_output;
  logic [2:0] serial_out;
  logic       frame_done;
  logic       frame_pending;

  int checks = 0;
  int errors = 0;

  param_shift_engine #(.WIDTH(8), .SHIFT_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .mode            (mode),
    .serial_in       (serial_in),
    .parallel_in     (parallel_in),
    .parallel_output (parallel_output),
    .serial_out      (serial_out),
    .frame_done      (frame_done),
    .frame_pending   (frame_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] m, input logic [2:0] si, input logic [7:0] pi);
    en          = 1'b1;
    mode        = m;
    serial_in   = si;
    parallel_in = pi;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 3'b000; serial_in = 3'b000; parallel_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    chk("rst_po", 32'(parallel_output), 32'h00);
    chk("rst_so", 32'(serial_out), 32'h0);
    chk("rst_done", 32'(frame_done), 32'h0);
    chk("rst_pend", 32'(frame_pending), 32'h0);

    // Shift right / left
    op(3'b101, 3'b000, 8'hAA);
    chk("load_po", 32'(parallel_output), 32'hAA);
    op(3'b001, 3'b001, 8'h00);
    chk("shr_po", 32'(parallel_output), 32'h35);
    chk("shr_so", 32'(serial_out), 32'h2);
    op(3'b101, 3'b000, 8'hAA);
    op(3'b010, 3'b100, 8'h00);
    chk("shl_po", 32'(parallel_output), 32'h54);
    chk("shl_so", 32'(serial_out), 32'h5);

    // Rotates and arithmetic shift; serial_in must be ignored by rotates
    op(3'b101, 3'b000, 8'hAA);
    chk("load_so_hold", 32'(serial_out), 32'h5);
    op(3'b011, 3'b111, 8'h00);
    chk("ror_po", 32'(parallel_output), 32'h55);
    chk("ror_so", 32'(serial_out), 32'h2);
    op(3'b101, 3'b000, 8'hAA);
    op(3'b111, 3'b000, 8'h00);
    chk("asr_po", 32'(parallel_output), 32'hF5);
    chk("asr_so", 32'(serial_out), 32'h2);
    op(3'b101, 3'b000, 8'hAA);
    op(3'b100, 3'b111, 8'h00);
    chk("rol_po", 32'(parallel_output), 32'h55);
    chk("rol_so", 32'(serial_out), 32'h5);

    // Deserialize a full frame
    op(3'b110, 3'b101, 8'h00);
    chk("des1_pend", 32'(frame_pending), 32'h1);
    chk("des1_po", 32'(parallel_output), 32'h55);
    chk("des1_done", 32'(frame_done), 32'h0);
    op(3'b110, 3'b011, 8'h00);
    chk("des2_pend", 32'(frame_pending), 32'h1);
    chk("des2_done", 32'(frame_done), 32'h0);
    op(3'b110, 3'b110, 8'h00);
    chk("des3_po", 32'(parallel_output), 32'h9D);
    chk("des3_done", 32'(frame_done), 32'h1);
    chk("des3_pend", 32'(frame_pending), 32'h0);
    chk("des3_so", 32'(serial_out), 32'h5);
    idle();
    chk("des_pulse_end", 32'(frame_done), 32'h0);

    // Abort mid-frame, then a fresh frame with stalls and hold-mode cycles
    op(3'b101, 3'b000, 8'h00);
    op(3'b110, 3'b101, 8'h00);
    op(3'b110, 3'b011, 8'h00);
    op(3'b001, 3'b000, 8'h00);
    chk("abort_pend", 32'(frame_pending), 32'h0);
    chk("abort_done", 32'(frame_done), 32'h0);
    chk("abort_po", 32'(parallel_output), 32'h00);
    op(3'b110, 3'b101, 8'h00);
    idle();
    chk("stall_pend", 32'(frame_pending), 32'h1);
    op(3'b000, 3'b010, 8'hFF);
    chk("holdmode_pend", 32'(frame_pending), 32'h1);
    op(3'b110, 3'b011, 8'h00);
    idle();
    chk("stall2_done", 32'(frame_done), 32'h0);
    chk("stall2_po", 32'(parallel_output), 32'h00);
    op(3'b110, 3'b110, 8'h00);
    chk("refr_po", 32'(parallel_output), 32'h9D);
    chk("refr_done", 32'(frame_done), 32'h1);
    idle();
    chk("refr_pulse_end", 32'(frame_done), 32'h0);

    // Asynchronous reset mid-frame
    op(3'b110, 3'b101, 8'h00);
    chk("pre_rst_pend", 32'(frame_pending), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_po", 32'(parallel_output), 32'h00);
    chk("arst_pend", 32'(frame_pending), 32'h0);
    chk("arst_so", 32'(serial_out), 32'h0);
    chk("arst_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    op(3'b110, 3'b101, 8'h00);
    op(3'b110, 3'b011, 8'h00);
    chk("post_rst_nodone", 32'(frame_done), 32'h0);
    op(3'b110, 3'b110, 8'h00);
    chk("post_rst_po", 32'(parallel_output), 32'h9D);
    chk("post_rst_done", 32'(frame_done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_shift_engine.md
Name: param_shift_engine

Overview:
Parametrised universal shift register for WIDTH-bit data, shifting SHIFT_W bits per enabled cycle. Modes: hold, logical shift left/right, rotate left/right, arithmetic right shift, parallel load, and a deserialize mode. In deserialize mode, serial chunks accumulate in a staging register and the assembled frame is committed to the output register. Sits between serial front-end logic and 8-bit-class parallel datapaths; it is the general-width successor of the fixed 8-bit/3-bit shift block.

Parameters:
WIDTH, 8, data register width; must be >= 2.
SHIFT_W, 3, bits shifted per cycle / serial chunk width; 1 <= SHIFT_W < WIDTH.
CHUNKS, ceil(WIDTH/SHIFT_W), derived localparam; chunks per deserialized frame.
STAGE_W, CHUNKS*SHIFT_W, derived localparam; staging register width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
en  input  1  operation enable; 0 = every register holds.
mode  input  3  operation select (encodings below).
serial_in  input  SHIFT_W  chunk shifted in.
parallel_in  input  WIDTH  load value.
parallel_output  output  WIDTH  main data register.
serial_out  output  SHIFT_W  chunk shifted out by the last shift; registered.
frame_done  output  1  one-cycle pulse: deserialized frame committed.
frame_pending  output  1  high while a partial frame is in staging (chunk_cnt != 0).

Behaviour:
- Reset (reset=0, async): parallel_output=0, stage=0, chunk_cnt=0, serial_out=0, frame_done=0. Takes priority over everything, including mid-frame.
- en=0: all registers hold; frame_done=0.
- frame_done defaults to 0 every cycle unless set below.
- With en=1, per mode (d = parallel_output):
- 000 hold: d holds; stage and chunk_cnt hold.
- 001 shift right: d <= {serial_in, d[WIDTH-1:SHIFT_W]}; serial_out <= d[SHIFT_W-1:0].
- 010 shift left: d <= {d[WIDTH-1-SHIFT_W:0], serial_in}; serial_out <= d[WIDTH-1 -: SHIFT_W].
- 011 rotate right by SHIFT_W; serial_out <= d[SHIFT_W-1:0]. serial_in is ignored.
- 100 rotate left by SHIFT_W; serial_out <= d[WIDTH-1 -: SHIFT_W]. serial_in is ignored.
- 101 parallel load: d <= parallel_in; serial_out holds.
- 110 deserialize: stage <= {serial_in, stage[STAGE_W-1:SHIFT_W]} (new chunk enters at the top; the first chunk ends in the lowest bits).
  - If chunk_cnt == CHUNKS-1: d <= stage_next[WIDTH-1:0], frame_done=1, chunk_cnt <= 0. Top STAGE_W-WIDTH bits are discarded.
  - Otherwise chunk_cnt++ and d holds.
- 111 arithmetic shift right: d <= {{SHIFT_W{d[WIDTH-1]}}, d[WIDTH-1:SHIFT_W]}; serial_out <= d[SHIFT_W-1:0].
- Abort rule: en=1 with any mode other than 000 or 110 clears chunk_cnt to 0. The partial frame is discarded, no frame_done is raised, and stage contents are left stale (don't-care).
- Latency: every operation is visible on parallel_output one cycle after the sampling edge; frame_done is aligned with the commit of the frame.
- chunk_cnt is $clog2(CHUNKS) bits wide (minimum 1) and wraps only through the commit path.
- Output-width rules: no arithmetic beyond the counter; all shifts are fixed-distance slices. No combinational path from inputs to outputs.

Decomposition:
- Shared package (shift_pkg): mode encodings as named constants (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_LOAD, MODE_DESER, MODE_ASR) and a CHUNKS ceiling-divide function.
- One natural sub-module: shift_deser_stage (staging register + chunk counter + commit/abort logic). The mode mux and main register stay in the top module.

Test Plan (WIDTH=8, SHIFT_W=3, so CHUNKS=3, STAGE_W=9):
1. Hold reset=0 for 2 cycles, then release -> parallel_output=0x00, serial_out=3'b000, frame_done=0, frame_pending=0.
2. Load 0xAA (mode 101), then one cycle of mode 001 with serial_in=3'b001 -> parallel_output=0x35, serial_out=3'b010. Reload 0xAA, then mode 010 with serial_in=3'b100 -> parallel_output=0x54, serial_out=3'b101.
3. Load 0xAA, then mode 011 -> 0x55. Reload 0xAA, then mode 111 -> 0xF5. Reload 0xAA, then mode 100 -> 0x55. In each case verify serial_out against the rule for that mode.
4. Mode 110 with chunks 3'b101, 3'b011, 3'b110 on consecutive cycles -> frame_pending high after the 1st and 2nd chunks; on the 3rd edge parallel_output=0x9D and frame_done pulses for exactly 1 cycle.
5. Send two chunks, then one cycle of mode 001 (abort) -> frame_pending=0, no frame_done. Then send 3 fresh chunks 101/011/110 -> 0x9D committed with a single pulse. Check that en=0 inserted mid-frame stalls without loss.
6. Drive reset low asynchronously after one chunk (between clock edges) -> all outputs go to 0 immediately. After release, a complete 3-chunk frame commits correctly.
